// File: rtl/fixedn_pkg.sv
// -----------------------------------------------------------------------------
// fixedn_pkg
// Shared constants for the fixedn channel generator:
//   SEL_*   register-select codes (low two bits of the config address)
//   MODE_*  channel operating modes (bit 0 of the MODE register)
//   CNT_W   width of the per-channel ramp counter and PERIOD register
// -----------------------------------------------------------------------------
package fixedn_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] SEL_BASE   = 2'd0;
    localparam logic [1:0] SEL_STEP   = 2'd1;
    localparam logic [1:0] SEL_PERIOD = 2'd2;
    localparam logic [1:0] SEL_MODE   = 2'd3;

    localparam logic MODE_CONST = 1'b0;
    localparam logic MODE_RAMP  = 1'b1;

endpackage : fixedn_pkg

// File: rtl/fixedn_chan.sv
// -----------------------------------------------------------------------------
// fixedn_chan
// One output channel: BASE/STEP/PERIOD/MODE configuration registers plus the
// running accumulator (ACC) and period counter (CNT).
//   clk      : clock, all state on the rising edge
//   srst     : synchronous active-high reset, clears config and run state
//   init_i   : run-state re-initialisation (ACC <= BASE, CNT <= 0), config kept
//   dis_i    : freezes ACC/CNT and suppresses the wrap pulse
//   we_i     : config write strobe, already qualified for this channel
//   sel_i    : register select (SEL_BASE..SEL_MODE)
//   wdata_i  : config write data
//   out_o    : channel value (ACC)
//   wrap_o   : one-cycle pulse after the ramp returns to BASE
// DATA_W must be at least CNT_W, since PERIOD takes the low CNT_W bits.
// -----------------------------------------------------------------------------
module fixedn_chan
    import fixedn_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              init_i,
    input  logic              dis_i,
    input  logic              we_i,
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] out_o,
    output logic              wrap_o
);

    logic [DATA_W-1:0] base_q,   base_d;
    logic [DATA_W-1:0] step_q,   step_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              mode_q,   mode_d;
    logic [DATA_W-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              wrap_q,   wrap_d;

    logic mode_wr;
    logic last_step;

    assign mode_wr = we_i && (sel_i == SEL_MODE);

    // PERIOD == 0 never matches, giving the free-running ramp.
    assign last_step = (period_q != '0) && (cnt_q == period_q - CNT_W'(1));

    always_comb begin
        base_d   = base_q;
        step_d   = step_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (we_i) begin
            unique case (sel_i)
                SEL_BASE:   base_d   = wdata_i;
                SEL_STEP:   step_d   = wdata_i;
                SEL_PERIOD: period_d = wdata_i[CNT_W-1:0];
                default:    mode_d   = wdata_i[0];
            endcase
        end
    end

    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (init_i) begin
            // base_d so that a BASE write on the same edge is picked up.
            acc_d = base_d;
            cnt_d = '0;
        end else if (mode_wr) begin
            acc_d = base_q;
            cnt_d = '0;
        end else if (dis_i) begin
            acc_d = acc_q;
            cnt_d = cnt_q;
        end else if (mode_q == MODE_CONST) begin
            // Tracking base_d makes a new BASE visible one cycle after its write.
            acc_d = base_d;
            cnt_d = '0;
        end else if (last_step) begin
            acc_d  = base_q;
            cnt_d  = '0;
            wrap_d = 1'b1;
        end else begin
            acc_d = acc_q + step_q;
            if ((period_q == '0) && (cnt_q == '1)) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            base_q   <= '0;
            step_q   <= '0;
            period_q <= '0;
            mode_q   <= MODE_CONST;
            acc_q    <= '0;
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
        end else begin
            base_q   <= base_d;
            step_q   <= step_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out_o  = acc_q;
    assign wrap_o = wrap_q;

endmodule : fixedn_chan

// File: rtl/fixedn.sv
// -----------------------------------------------------------------------------
// fixedn
// NCH independent constant/ramp generators sharing one config write port.
//   fixedn_clk        : clock
//   fixedn_reset      : synchronous active-high reset (config + run state)
//   fixedn_init       : run-state re-initialisation, config kept
//   fixedn_in_disable : freeze all channels, wrap pulses suppressed
//   fixedn_cfg_we     : config write strobe
//   fixedn_cfg_addr   : {channel index, register select}
//   fixedn_cfg_wdata  : config write data
//   fixedn_out        : channel c on [c*DATA_W +: DATA_W]
//   fixedn_wrap       : per-channel wrap pulse
// The top only decodes the channel index; writes to an index with no channel
// match no strobe and are dropped.
// -----------------------------------------------------------------------------
module fixedn
    import fixedn_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NCH    = 4
) (
    input  logic                       fixedn_clk,
    input  logic                       fixedn_reset,
    input  logic                       fixedn_init,
    input  logic                       fixedn_in_disable,
    input  logic                       fixedn_cfg_we,
    input  logic [$clog2(NCH)+2-1:0]   fixedn_cfg_addr,
    input  logic [DATA_W-1:0]          fixedn_cfg_wdata,
    output logic [NCH*DATA_W-1:0]      fixedn_out,
    output logic [NCH-1:0]             fixedn_wrap
);

    localparam int AW    = $clog2(NCH) + 2;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic [1:0]       sel;
    logic [IDX_W-1:0] idx;

    assign sel = fixedn_cfg_addr[1:0];

    // A single-channel build has no index field in the address.
    generate
        if (NCH > 1) begin : g_idx
            assign idx = fixedn_cfg_addr[AW-1:2];
        end else begin : g_noidx
            assign idx = '0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic we_c;
            assign we_c = fixedn_cfg_we && (idx == IDX_W'(gi));

            fixedn_chan #(
                .DATA_W (DATA_W)
            ) u_chan (
                .clk     (fixedn_clk),
                .srst    (fixedn_reset),
                .init_i  (fixedn_init),
                .dis_i   (fixedn_in_disable),
                .we_i    (we_c),
                .sel_i   (sel),
                .wdata_i (fixedn_cfg_wdata),
                .out_o   (fixedn_out[gi*DATA_W +: DATA_W]),
                .wrap_o  (fixedn_wrap[gi])
            );
        end
    endgenerate

endmodule : fixedn

// File: tb/tb_fixedn.sv
// -----------------------------------------------------------------------------
// tb_fixedn
// Directed vectors for fixedn. Built with NCH=3 so the 2-bit channel index
// field can address a channel (index 3) that does not exist.
// Each table row is driven for one clock edge; the expected outputs are the
// values visible just after that edge.
// -----------------------------------------------------------------------------
module tb_fixedn;

    localparam int DATA_W = 32;
    localparam int NCH    = 3;
    localparam int AW     = $clog2(NCH) + 2;

    logic                  clk;
    logic                  rst;
    logic                  init;
    logic                  dis;
    logic                  we;
    logic [AW-1:0]         addr;
    logic [DATA_W-1:0]     wdata;
    logic [NCH*DATA_W-1:0] out;
    logic [NCH-1:0]        wrap;

    int checks = 0;
    int errors = 0;

    fixedn #(
        .DATA_W (DATA_W),
        .NCH    (NCH)
    ) dut (
        .fixedn_clk        (clk),
        .fixedn_reset      (rst),
        .fixedn_init       (init),
        .fixedn_in_disable (dis),
        .fixedn_cfg_we     (we),
        .fixedn_cfg_addr   (addr),
        .fixedn_cfg_wdata  (wdata),
        .fixedn_out        (out),
        .fixedn_wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                  we;
        logic [AW-1:0]         addr;
        logic [DATA_W-1:0]     wdata;
        logic                  init;
        logic                  dis;
        logic [NCH*DATA_W-1:0] exp_out;
        logic [NCH-1:0]        exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic w, input int a, input logic [31:0] d,
                       input logic in, input logic ds,
                       input logic [31:0] o0, input logic [31:0] o1,
                       input logic [31:0] o2, input logic [2:0] wr);
        vec_t v;
        v.we       = w;
        v.addr     = AW'(a);
        v.wdata    = d;
        v.init     = in;
        v.dis      = ds;
        v.exp_out  = {o2, o1, o0};
        v.exp_wrap = wr;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name, input logic [NCH*DATA_W-1:0] exp_o,
                             input logic [NCH-1:0] exp_w);
        checks++;
        if (out !== exp_o) begin
            errors++;
            $display("FAIL %s out: got %h expected %h", name, out, exp_o);
        end
        checks++;
        if (wrap !== exp_w) begin
            errors++;
            $display("FAIL %s wrap: got %b expected %b", name, wrap, exp_w);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        init  = 1'b0;
        dis   = 1'b0;
    endtask

    initial begin
        // addr = channel*4 + select
        //   we  addr data          init dis  ch0        ch1   ch2         wrap
        add(1,  0, 32'h1234,      0, 0, 32'h1234, 0,  0,           3'b000); // ch0 BASE
        add(1,  3, 0,             0, 0, 32'h1234, 0,  0,           3'b000); // ch0 MODE const
        add(1,  4, 10,            0, 0, 32'h1234, 10, 0,           3'b000); // ch1 BASE
        add(1,  5, 3,             0, 0, 32'h1234, 10, 0,           3'b000); // ch1 STEP
        add(1,  6, 4,             0, 0, 32'h1234, 10, 0,           3'b000); // ch1 PERIOD
        add(1,  7, 1,             0, 0, 32'h1234, 10, 0,           3'b000); // ch1 RAMP
        add(0,  0, 0,             0, 0, 32'h1234, 13, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 16, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 19, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 10, 0,           3'b010); // wrap
        add(0,  0, 0,             0, 0, 32'h1234, 13, 0,           3'b000);
        add(0,  0, 0,             0, 1, 32'h1234, 13, 0,           3'b000); // disable x3
        add(0,  0, 0,             0, 1, 32'h1234, 13, 0,           3'b000);
        add(0,  0, 0,             0, 1, 32'h1234, 13, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 16, 0,           3'b000); // resumes
        add(0,  0, 0,             0, 0, 32'h1234, 19, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 10, 0,           3'b010);
        add(0,  0, 0,             0, 0, 32'h1234, 13, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 16, 0,           3'b000); // CNT=2
        add(1,  4, 50,            1, 0, 32'h1234, 50, 0,           3'b000); // init + BASE
        add(0,  0, 0,             0, 0, 32'h1234, 53, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 56, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 59, 0,           3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 50, 0,           3'b010);
        add(1,  7, 0,             0, 0, 32'h1234, 50, 0,           3'b000); // ch1 const
        add(1,  8, 32'hFFFFFFFE,  0, 0, 32'h1234, 50, 32'hFFFFFFFE, 3'b000); // ch2 BASE
        add(1,  9, 1,             0, 0, 32'h1234, 50, 32'hFFFFFFFE, 3'b000);
        add(1, 10, 0,             0, 0, 32'h1234, 50, 32'hFFFFFFFE, 3'b000);
        add(1, 11, 1,             0, 0, 32'h1234, 50, 32'hFFFFFFFE, 3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 50, 32'hFFFFFFFF, 3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 50, 32'h0,        3'b000);
        add(0,  0, 0,             0, 0, 32'h1234, 50, 32'h1,        3'b000);
        add(1, 12, 32'hDEAD,      0, 0, 32'h1234, 50, 32'h2,        3'b000); // idx 3 ignored
        add(1, 13, 32'h77,        0, 0, 32'h1234, 50, 32'h3,        3'b000);
        add(1, 15, 1,             0, 0, 32'h1234, 50, 32'h4,        3'b000);
        add(1,  1, 7,             0, 0, 32'h1234, 50, 32'h5,        3'b000); // ch0 STEP
        add(1,  2, 1,             0, 0, 32'h1234, 50, 32'h6,        3'b000); // ch0 PERIOD=1
        add(1,  3, 1,             0, 0, 32'h1234, 50, 32'h7,        3'b000); // ch0 RAMP
        add(0,  0, 0,             0, 0, 32'h1234, 50, 32'h8,        3'b001);
        add(0,  0, 0,             0, 0, 32'h1234, 50, 32'h9,        3'b001);
        add(0,  0, 0,             0, 1, 32'h1234, 50, 32'h9,        3'b000);

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        check_out("reset", '0, '0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            we    = vecs[i].we;
            addr  = vecs[i].addr;
            wdata = vecs[i].wdata;
            init  = vecs[i].init;
            dis   = vecs[i].dis;
            step();
            $display("vec %0d we=%0d addr=%0d wdata=%h init=%0d dis=%0d out=%h wrap=%b",
                     i, we, addr, wdata, init, dis, out, wrap);
            check_out($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_wrap);
        end

        // Reset mid-run clears everything, including the ch0 PERIOD=1 wrap stream.
        idle_inputs();
        rst = 1'b1;
        step();
        check_out("reset2", '0, '0);
        rst = 1'b0;
        step();
        check_out("post_reset_idle", '0, '0);

        // STEP was cleared: a ramp on ch2 stays at BASE=0 and never wraps.
        we = 1'b1; addr = AW'(11); wdata = 32'd1;
        step();
        check_out("ramp_after_reset", '0, '0);
        idle_inputs();
        step();
        step();
        check_out("ramp_after_reset2", '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fixedn

// File: doc/fixedn.md
FIXEDN -- requirements
Module: fixedn

Interface
REQ-001 Parameter DATA_W, default 32, width of each channel value.
REQ-002 Parameter NCH, default 4, channel count (1..16).
REQ-003 fixedn_clk  input  1  sole clock; all state on rising edge.
REQ-004 fixedn_reset  input  1  reset, synchronous and active-high.
REQ-005 fixedn_init  input  1  synchronous run-state re-initialisation, active-high; configuration kept.
REQ-006 fixedn_in_disable  input  1  high freezes all channel run state and holds outputs.
REQ-007 fixedn_cfg_we  input  1  configuration write strobe.
REQ-008 fixedn_cfg_addr  input  $clog2(NCH)+2  {channel index, register select}; select 0 BASE, 1 STEP, 2 PERIOD, 3 MODE.
REQ-009 fixedn_cfg_wdata  input  DATA_W  write data; MODE uses bit 0 only, PERIOD uses the low 16 bits.
REQ-010 fixedn_out  output  NCH*DATA_W  channel c on bits [c*DATA_W +: DATA_W].
REQ-011 fixedn_wrap  output  NCH  one-cycle pulse per channel on ramp wrap.

Function
REQ-012 Internal run-state clear shall be reset_i = fixedn_reset | fixedn_init; config clear shall use fixedn_reset only.
REQ-013 Each channel shall hold BASE, STEP, PERIOD and MODE registers plus accumulator ACC (DATA_W) and count CNT (16 bits).
REQ-014 MODE 0 (CONST): channel output shall equal BASE, visible the cycle after the BASE write edge; ACC and CNT held at BASE and 0.
REQ-015 MODE 1 (RAMP): output shall equal ACC; on each edge with in_disable low, ACC <= ACC+STEP modulo 2^DATA_W and CNT <= CNT+1.
REQ-016 RAMP wrap: when CNT == PERIOD-1 on an advancing edge, ACC <= BASE, CNT <= 0, and fixedn_wrap[c] shall be 1 the following cycle.
REQ-017 PERIOD == 0 shall mean free-running: no wrap, CNT saturates at 16'hFFFF, ACC continues modulo.
REQ-018 PERIOD == 1 shall hold ACC at BASE every cycle with fixedn_wrap[c] high continuously.
REQ-019 A MODE write shall reload ACC <= BASE and CNT <= 0 on the same edge.
REQ-020 A BASE, STEP or PERIOD write during RAMP shall not disturb ACC/CNT; new BASE used at next wrap or init.
REQ-021 in_disable high: ACC, CNT frozen, fixedn_wrap all 0; config writes still accepted.
REQ-022 Write with channel index >= NCH shall be ignored.
REQ-023 init and cfg write on the same edge: register is written and ACC reloads from the newly written BASE.
REQ-024 init shall have priority over in_disable and over advancing.

Reset
REQ-025 On fixedn_reset: BASE, STEP, PERIOD, MODE, ACC, CNT = 0; fixedn_out = 0; fixedn_wrap = 0 the following cycle.
REQ-026 On fixedn_init alone: ACC <= BASE, CNT <= 0, fixedn_wrap = 0; config unchanged.

Structure
REQ-027 Package fixedn_pkg shall hold register-select constants (SEL_BASE..SEL_MODE), mode constants (MODE_CONST, MODE_RAMP) and CNT_W = 16.
REQ-028 One sub-module fixedn_chan (one channel's registers, ACC/CNT, wrap) instantiated NCH times; top decodes address only.

Verification
REQ-029 reset, write ch0 BASE=0x1234, MODE=0 -> out[ch0]=0x1234 next cycle, other channels 0.
REQ-030 ch1 BASE=10, STEP=3, PERIOD=4, MODE=1 -> out 10,13,16,19,10,...; wrap[1] high the cycle out returns to 10.
REQ-031 ch2 BASE=0xFFFFFFFE, STEP=1, PERIOD=0, RAMP -> out FFFFFFFE, FFFFFFFF, 0, 1; wrap never set.
REQ-032 ramp running, in_disable high 3 cycles mid-sequence -> out held, wrap 0, sequence resumes with no skipped value.
REQ-033 ramp at CNT=2, pulse init together with BASE write 50 -> next out 50, CNT 0, STEP/PERIOD retained.
REQ-034 write to channel index NCH (NCH=4, index 4 unused when width allows) -> no register changes on any channel.
